// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Brief    : Generic pipeline stage register with valid/ready handshake,
//            2-entry skid buffer, synchronous flush and optional
//            saturating performance counters.
// Options  : define PIPE_STAGE_SKID_PERF_EN to build stall_cnt/flush_cnt;
//            otherwise both counter ports are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
   parameter int WIDTH      = 32,
   parameter int CTRL_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic [1:0]            occupancy,
   output logic [CNT_WIDTH-1:0]  stall_cnt,
   output logic [CNT_WIDTH-1:0]  flush_cnt
);

   // The state value doubles as the occupancy count.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   state_e                state_q,     state_d;
   logic                  in_ready_q,  in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic [WIDTH-1:0]      main_data_q, main_data_d;
   logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
   logic [WIDTH-1:0]      skid_data_q, skid_data_d;
   logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;

   logic                  in_fire;
   logic                  out_fire;

   // in_ready is held low while reset is asserted; the flop itself resets to 1.
   assign in_ready  = in_ready_q & ~reset;
   assign out_valid = out_valid_q;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid_q & out_ready;
   assign occupancy = state_q;
   assign out_data  = main_data_q;
   // Bubbles never leak stale control bits downstream.
   assign out_ctrl  = out_valid_q ? main_ctrl_q : '0;

   // Next-state, storage and registered-handshake computation.
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      if (flush) begin
         // Main data is kept; everything else that could look like a live
         // entry is cleared. An output transfer this cycle still completes.
         state_d     = ST_EMPTY;
         main_ctrl_d = '0;
         skid_data_d = '0;
         skid_ctrl_d = '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
                  state_d     = ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_fire && !out_fire) begin
                  skid_data_d = in_data;
                  skid_ctrl_d = in_ctrl;
                  state_d     = ST_FULL;
               end else if (in_fire && out_fire) begin
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end else if (out_fire) begin
                  state_d     = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
                  state_d     = ST_ONE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
      in_ready_d  = (state_d != ST_FULL);
      out_valid_d = (state_d != ST_EMPTY);
   end

   // Stage storage and handshake flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
      end
   end

`ifdef PIPE_STAGE_SKID_PERF_EN
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
   logic [1:0]           flush_inc;
   logic [CNT_WIDTH:0]   flush_sum;

   // Saturating counters: stall cycles and entries discarded by flush.
   always_comb begin
      // Entries lost = held - consumed this cycle + accepted this cycle (0..2).
      flush_inc   = occupancy - {1'b0, out_fire} + {1'b0, in_fire};
      flush_sum   = {1'b0, flush_cnt_q} + (CNT_WIDTH+1)'(flush_inc);
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (out_valid_q && !out_ready && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      end
      if (flush) begin
         flush_cnt_d = flush_sum[CNT_WIDTH] ? '1 : flush_sum[CNT_WIDTH-1:0];
      end
   end

   // Counter flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Brief    : Self-checking bench for pipe_stage_skid. A queue-based model of
//            the stage (FIFO of held entries, depth 2) predicts every output.
//            Honours PIPE_STAGE_SKID_PERF_EN for counter expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

   localparam int W  = 8;
   localparam int CW = 4;
   localparam int NW = 4;
   localparam int CNT_MAX = (1 << NW) - 1;
`ifdef PIPE_STAGE_SKID_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0]  d;
      logic [CW-1:0] c;
   } ent_t;

   logic          clk = 1'b0;
   logic          reset, flush, in_valid, out_ready;
   logic          in_ready, out_valid;
   logic [W-1:0]  in_data, out_data;
   logic [CW-1:0] in_ctrl, out_ctrl;
   logic [1:0]    occupancy;
   logic [NW-1:0] stall_cnt, flush_cnt;

   int tests = 0;
   int fails = 0;

   // Reference model state
   ent_t         q_m[$];
   logic         rdy_m = 1'b1;
   logic [W-1:0] main_m = '0;
   int           stall_m = 0;
   int           flush_m = 0;

   pipe_stage_skid #(.WIDTH(W), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
      .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > CNT_MAX) ? CNT_MAX : v;
   endfunction

   task automatic check_outputs(input logic rst);
      int n;
      n = q_m.size();
      chk("occupancy", 32'(occupancy), 32'(n));
      chk("out_valid", 32'(out_valid), 32'(n > 0));
      chk("out_data",  32'(out_data),  32'(main_m));
      chk("out_ctrl",  32'(out_ctrl),  (n > 0) ? 32'(q_m[0].c) : 32'd0);
      chk("in_ready",  32'(in_ready),  rst ? 32'd0 : 32'(rdy_m));
      chk("stall_cnt", 32'(stall_cnt), PERF ? 32'(stall_m) : 32'd0);
      chk("flush_cnt", 32'(flush_cnt), PERF ? 32'(flush_m) : 32'd0);
   endtask

   // One clock cycle: drive, check pre-edge outputs, clock, advance model.
   task automatic step(input logic iv, input logic [W-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl, input logic rst, input bit chk_en);
      bit in_f, out_f;
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      flush     = fl;
      reset     = rst;
      #1;
      if (chk_en) check_outputs(rst);
      in_f  = iv && rdy_m && !rst;
      out_f = (q_m.size() > 0) && ordy;
      @(posedge clk);
      if (rst) begin
         q_m.delete();
         rdy_m   = 1'b1;
         main_m  = '0;
         stall_m = 0;
         flush_m = 0;
      end else begin
         if (q_m.size() > 0 && !ordy) stall_m = sat(stall_m + 1);
         if (fl) begin
            flush_m = sat(flush_m + q_m.size() - int'(out_f) + int'(in_f));
            q_m.delete();
            rdy_m = 1'b1;
         end else begin
            if (out_f) void'(q_m.pop_front());
            if (in_f) q_m.push_back('{d: d, c: c});
            if (q_m.size() > 0) main_m = q_m[0].d;
            rdy_m = (q_m.size() < 2);
         end
      end
      @(negedge clk);
   endtask

   task automatic push(input logic [W-1:0] d, input logic ordy);
      step(1'b1, d, CW'(d + 8'h3), ordy, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, '0, '0, ordy, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      in_valid = 0; in_data = '0; in_ctrl = '0; out_ready = 0; flush = 0; reset = 1;
      @(negedge clk);
      // Reset: first edge unchecked (state unknown), then check reset values.
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h55, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(1'b0);

      // Streaming with out_ready held high.
      push(8'h10, 1'b1);
      push(8'h11, 1'b1);
      chk("stream_occ", 32'(occupancy), 32'd1);
      push(8'h12, 1'b1);
      chk("stream_rdy", 32'(in_ready), 32'd1);
      idle(1'b1);
      idle(1'b1);

      // Skid fill then drain.
      push(8'h0A, 1'b0);
      push(8'h0B, 1'b0);
      chk("skid_occ",  32'(occupancy), 32'd2);
      chk("skid_rdy",  32'(in_ready),  32'd0);
      chk("skid_head", 32'(out_data),  32'h0A);
      idle(1'b0);
      idle(1'b1);
      chk("drain_b",   32'(out_data),  32'h0B);
      idle(1'b1);
      idle(1'b1);

      // Flush while FULL.
      push(8'h21, 1'b0);
      push(8'h22, 1'b0);
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("flush_full_valid", 32'(out_valid), 32'd0);
      chk("flush_full_ctrl",  32'(out_ctrl),  32'd0);
      chk("flush_full_rdy",   32'(in_ready),  32'd1);
      chk("flush_full_cnt",   32'(flush_cnt), PERF ? 32'd2 : 32'd0);
      idle(1'b0);

      // Flush together with input and output fire in ONE.
      push(8'h31, 1'b0);
      step(1'b1, 8'h32, 4'h9, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("flush_fire_occ", 32'(occupancy), 32'd0);
      chk("flush_fire_cnt", 32'(flush_cnt), PERF ? 32'd3 : 32'd0);
      idle(1'b1);

      // Reset mid-stream from FULL with stalls accumulated.
      push(8'h41, 1'b0);
      push(8'h42, 1'b0);
      for (int i = 0; i < 4; i++) idle(1'b0);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("rst_mid_occ",  32'(occupancy), 32'd0);
      chk("rst_mid_data", 32'(out_data),  32'd0);
      push(8'h43, 1'b1);
      chk("rst_mid_push", 32'(out_data),  32'h43);
      idle(1'b1);

      // Stall-counter saturation.
      push(8'h51, 1'b0);
      for (int i = 0; i < 20; i++) idle(1'b0);
      chk("stall_sat", 32'(stall_cnt), PERF ? 32'(CNT_MAX) : 32'd0);
      idle(1'b1);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(3, 0) != 0), 8'($urandom), 4'($urandom),
              ($urandom_range(2, 0) != 0), ($urandom_range(15, 0) == 0),
              ($urandom_range(63, 0) == 0), 1'b1);
      end
      idle(1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
